aq_ejpeg_rgb2ycbcr: RTL and testbench

JPEG encoder colour converter, the inverse of the decoder's YCbCr->RGB stage. It accepts one MCU of RGB pixels in MCU-raster order and converts them with a fixed-point pipeline into level-shifted signed Y/Cb/Cr. It writes Y into the luma block buffer and decimated Cb/Cr into the chroma block buffers, with the same address layouts the decoder reads. It sits between the pixel source (frame fetch) and the forward DCT.

---
 rtl/aq_ejpeg_pkg.sv | 31 +++
 rtl/aq_ejpeg_rgb2ycbcr_csc_pipe.sv | 163 ++++++++++++++++
 rtl/aq_ejpeg_rgb2ycbcr.sv | 139 +++++++++++++
 tb/tb_aq_ejpeg_rgb2ycbcr.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_ejpeg_pkg.sv
// ---------------------------------------------------------------------------
// aq_ejpeg_pkg
// Shared constants for the JPEG encoder colour converter:
//   - Q14 RGB->YCbCr coefficients (each chroma row sums to zero so grey
//     input produces exactly zero chroma; the luma row sums to 1.0 = 16384)
//   - rounding constant, luma level shift, fraction width
//   - converter FSM state encoding
// ---------------------------------------------------------------------------
package aq_ejpeg_pkg;

   localparam logic signed [31:0] C_YR  =  32'sd4899;
   localparam logic signed [31:0] C_YG  =  32'sd9617;
   localparam logic signed [31:0] C_YB  =  32'sd1868;
   localparam logic signed [31:0] C_CBR = -32'sd2765;
   localparam logic signed [31:0] C_CBG = -32'sd5427;
   localparam logic signed [31:0] C_CBB =  32'sd8192;
   localparam logic signed [31:0] C_CRR =  32'sd8192;
   localparam logic signed [31:0] C_CRG = -32'sd6860;
   localparam logic signed [31:0] C_CRB = -32'sd1332;

   localparam logic signed [31:0] ROUND       = 32'sd8192;
   localparam logic signed [31:0] LEVEL_SHIFT = 32'sd128;
   localparam int                 FRAC_BITS   = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/aq_ejpeg_rgb2ycbcr_csc_pipe.sv
// ---------------------------------------------------------------------------
// aq_ejpeg_csc_pipe
// Stall-able RGB->YCbCr datapath. A capture register takes the accepted
// pixel, then S1 multiplies, S2 sums, S3 rounds/saturates into the output
// registers. Valid, luma address, chroma address and chroma-write flag ride
// alongside the data. Everything advances only when i_adv is high.
// Ports:
//   clk, rst (sync, active-low)   clock / reset
//   i_clear                       drops all in-flight valids (new image)
//   i_adv                         pipeline advance (downstream ready)
//   i_vld, i_r/i_g/i_b            accepted pixel
//   i_addr_y, i_cen, i_addr_c     luma address, chroma write flag/address
//   o_busy                        any of the first three ranks holds a pixel
//   o_en_y/o_addr_y/o_y           luma write
//   o_en_c/o_addr_c/o_cb/o_cr     chroma write
// ---------------------------------------------------------------------------
module aq_ejpeg_csc_pipe
   import aq_ejpeg_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_adv,
   input  logic              i_vld,
   input  logic [7:0]        i_r,
   input  logic [7:0]        i_g,
   input  logic [7:0]        i_b,
   input  logic [7:0]        i_addr_y,
   input  logic              i_cen,
   input  logic [5:0]        i_addr_c,
   output logic              o_busy,
   output logic              o_en_y,
   output logic [7:0]        o_addr_y,
   output logic signed [8:0] o_y,
   output logic              o_en_c,
   output logic [5:0]        o_addr_c,
   output logic signed [8:0] o_cb,
   output logic signed [8:0] o_cr
);

   function automatic logic signed [8:0] f_round_sat(input logic signed [31:0] i_acc,
                                                     input logic signed [31:0] i_off);
      logic signed [31:0] w_t;
      w_t = ((i_acc + ROUND) >>> FRAC_BITS) - i_off;
      if (w_t > 32'sd127)
         return 9'sd127;
      else if (w_t < -32'sd128)
         return -9'sd128;
      else
         return w_t[8:0];
   endfunction

   logic              r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3;
   logic              r_cen_p0, r_cen_p1, r_cen_p2, r_cen_p3;
   logic [7:0]        r_r_p0, r_g_p0, r_b_p0;
   logic [7:0]        r_ay_p0, r_ay_p1, r_ay_p2, r_ay_p3;
   logic [5:0]        r_ac_p0, r_ac_p1, r_ac_p2, r_ac_p3;
   logic signed [31:0] r_yr_p1, r_yg_p1, r_yb_p1;
   logic signed [31:0] r_cbr_p1, r_cbg_p1, r_cbb_p1;
   logic signed [31:0] r_crr_p1, r_crg_p1, r_crb_p1;
   logic signed [31:0] r_ys_p2, r_cbs_p2, r_crs_p2;
   logic signed [8:0]  r_y_p3, r_cb_p3, r_cr_p3;
   logic signed [31:0] w_r, w_g, w_b;

   // pixel components are unsigned; zero-extend before signed multiply
   assign w_r = {24'd0, r_r_p0};
   assign w_g = {24'd0, r_g_p0};
   assign w_b = {24'd0, r_b_p0};

   always_ff @(posedge clk) begin
      if (!rst || i_clear) begin
         r_vld_p0 <= 1'b0;
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
         r_vld_p3 <= 1'b0;
         r_cen_p0 <= 1'b0;
         r_cen_p1 <= 1'b0;
         r_cen_p2 <= 1'b0;
         r_cen_p3 <= 1'b0;
      end else if (i_adv) begin
         r_vld_p0 <= i_vld;
         r_cen_p0 <= i_vld & i_cen;
         r_vld_p1 <= r_vld_p0;
         r_cen_p1 <= r_cen_p0;
         r_vld_p2 <= r_vld_p1;
         r_cen_p2 <= r_cen_p1;
         r_vld_p3 <= r_vld_p2;
         r_cen_p3 <= r_cen_p2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_r_p0   <= '0;
         r_g_p0   <= '0;
         r_b_p0   <= '0;
         r_ay_p0  <= '0;
         r_ac_p0  <= '0;
         r_yr_p1  <= '0;
         r_yg_p1  <= '0;
         r_yb_p1  <= '0;
         r_cbr_p1 <= '0;
         r_cbg_p1 <= '0;
         r_cbb_p1 <= '0;
         r_crr_p1 <= '0;
         r_crg_p1 <= '0;
         r_crb_p1 <= '0;
         r_ay_p1  <= '0;
         r_ac_p1  <= '0;
         r_ys_p2  <= '0;
         r_cbs_p2 <= '0;
         r_crs_p2 <= '0;
         r_ay_p2  <= '0;
         r_ac_p2  <= '0;
         r_y_p3   <= '0;
         r_cb_p3  <= '0;
         r_cr_p3  <= '0;
         r_ay_p3  <= '0;
         r_ac_p3  <= '0;
      end else if (i_adv) begin
         // capture
         r_r_p0   <= i_r;
         r_g_p0   <= i_g;
         r_b_p0   <= i_b;
         r_ay_p0  <= i_addr_y;
         r_ac_p0  <= i_addr_c;
         // S1: multiply
         r_yr_p1  <= C_YR  * w_r;
         r_yg_p1  <= C_YG  * w_g;
         r_yb_p1  <= C_YB  * w_b;
         r_cbr_p1 <= C_CBR * w_r;
         r_cbg_p1 <= C_CBG * w_g;
         r_cbb_p1 <= C_CBB * w_b;
         r_crr_p1 <= C_CRR * w_r;
         r_crg_p1 <= C_CRG * w_g;
         r_crb_p1 <= C_CRB * w_b;
         r_ay_p1  <= r_ay_p0;
         r_ac_p1  <= r_ac_p0;
         // S2: sum
         r_ys_p2  <= r_yr_p1 + r_yg_p1 + r_yb_p1;
         r_cbs_p2 <= r_cbr_p1 + r_cbg_p1 + r_cbb_p1;
         r_crs_p2 <= r_crr_p1 + r_crg_p1 + r_crb_p1;
         r_ay_p2  <= r_ay_p1;
         r_ac_p2  <= r_ac_p1;
         // S3: round, level shift (luma only), saturate
         r_y_p3   <= f_round_sat(r_ys_p2, LEVEL_SHIFT);
         r_cb_p3  <= f_round_sat(r_cbs_p2, 32'sd0);
         r_cr_p3  <= f_round_sat(r_crs_p2, 32'sd0);
         r_ay_p3  <= r_ay_p2;
         r_ac_p3  <= r_ac_p2;
      end
   end

   assign o_busy   = r_vld_p0 | r_vld_p1 | r_vld_p2;
   assign o_en_y   = r_vld_p3;
   assign o_addr_y = r_ay_p3;
   assign o_y      = r_y_p3;
   assign o_en_c   = r_cen_p3;
   assign o_addr_c = r_ac_p3;
   assign o_cb     = r_cb_p3;
   assign o_cr     = r_cr_p3;

endmodule

// File: rtl/aq_ejpeg_rgb2ycbcr.sv
// ---------------------------------------------------------------------------
// aq_ejpeg_rgb2ycbcr
// JPEG encoder colour converter: takes one MCU of RGB pixels in MCU-raster
// order and writes level-shifted Y to the luma block buffer and top-left
// decimated Cb/Cr to the chroma block buffers.
// Ports:
//   clk, rst (sync, active-low), DataInit (sync abort for a new image)
//   Start, SubSamplingW/H          MCU start and luma sampling factors
//   InValid/InReady, InR/InG/InB   RGB pixel handshake
//   OutReady                       downstream ready; stalls everything when low
//   OutEnableY/OutAddressY/OutY    luma write
//   OutEnableCbCr/OutAddressCbCr/OutCb/OutCr  chroma write
//   Busy, Done                     status; Done pulses after the MCU's last write
// ---------------------------------------------------------------------------
module aq_ejpeg_rgb2ycbcr
   import aq_ejpeg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       DataInit,
   input  logic       Start,
   input  logic [1:0] SubSamplingW,
   input  logic [1:0] SubSamplingH,
   input  logic       InValid,
   output logic       InReady,
   input  logic [7:0] InR,
   input  logic [7:0] InG,
   input  logic [7:0] InB,
   input  logic       OutReady,
   output logic       OutEnableY,
   output logic [7:0] OutAddressY,
   output logic [8:0] OutY,
   output logic       OutEnableCbCr,
   output logic [5:0] OutAddressCbCr,
   output logic [8:0] OutCb,
   output logic [8:0] OutCr,
   output logic       Busy,
   output logic       Done
);

   state_t     r_state;
   logic       r_w2, r_h2;
   logic [3:0] r_x, r_y;
   logic       r_done;

   logic       w_accept, w_x_last, w_y_last, w_cen;
   logic [2:0] w_cx, w_cy;
   logic       w_pipe_busy, w_en_y, w_en_c;
   logic signed [8:0] w_y, w_cb, w_cr;

   assign InReady  = (r_state == RUN) && OutReady && !DataInit;
   assign w_accept = InValid && InReady;
   assign w_x_last = (r_x == (r_w2 ? 4'd15 : 4'd7));
   assign w_y_last = (r_y == (r_h2 ? 4'd15 : 4'd7));
   assign w_cx     = r_w2 ? r_x[3:1] : r_x[2:0];
   assign w_cy     = r_h2 ? r_y[3:1] : r_y[2:0];
   // top-left decimation: only even coordinates write chroma when subsampled
   assign w_cen    = (!r_w2 || !r_x[0]) && (!r_h2 || !r_y[0]);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_w2    <= 1'b0;
         r_h2    <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_done  <= 1'b0;
      end else if (DataInit) begin
         r_state <= IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (Start) begin
                  r_w2    <= (SubSamplingW == 2'd2);
                  r_h2    <= (SubSamplingH == 2'd2);
                  r_x     <= '0;
                  r_y     <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_accept) begin
                  if (w_x_last) begin
                     r_x <= '0;
                     r_y <= r_y + 4'd1;
                  end else begin
                     r_x <= r_x + 4'd1;
                  end
                  if (w_x_last && w_y_last)
                     r_state <= DRAIN;
               end
            end
            DRAIN: begin
               // finish on the edge that takes the final write
               if (!w_pipe_busy && (!w_en_y || OutReady)) begin
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   aq_ejpeg_csc_pipe u_pipe (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (DataInit),
      .i_adv    (OutReady),
      .i_vld    (w_accept),
      .i_r      (InR),
      .i_g      (InG),
      .i_b      (InB),
      .i_addr_y ({r_y, r_x}),
      .i_cen    (w_cen),
      .i_addr_c ({w_cy, w_cx}),
      .o_busy   (w_pipe_busy),
      .o_en_y   (w_en_y),
      .o_addr_y (OutAddressY),
      .o_y      (w_y),
      .o_en_c   (w_en_c),
      .o_addr_c (OutAddressCbCr),
      .o_cb     (w_cb),
      .o_cr     (w_cr)
   );

   assign OutY          = w_y;
   assign OutCb         = w_cb;
   assign OutCr         = w_cr;
   assign OutEnableY    = w_en_y && !DataInit;
   assign OutEnableCbCr = w_en_c && !DataInit;
   assign Busy          = (r_state != IDLE);
   assign Done          = r_done && !DataInit;

endmodule

// File: tb/tb_aq_ejpeg_rgb2ycbcr.sv
// ---------------------------------------------------------------------------
// tb_aq_ejpeg_rgb2ycbcr
// Scoreboard bench: expected luma/chroma writes are queued as pixels are
// accepted and popped as the converter issues writes.
// ---------------------------------------------------------------------------
module tb_aq_ejpeg_rgb2ycbcr;

   logic       clk = 1'b0;
   logic       rst, DataInit, Start, InValid, InReady, OutReady;
   logic [1:0] SubSamplingW, SubSamplingH;
   logic [7:0] InR, InG, InB;
   logic       OutEnableY, OutEnableCbCr, Busy, Done;
   logic [7:0] OutAddressY;
   logic [5:0] OutAddressCbCr;
   logic [8:0] OutY, OutCb, OutCr;

   typedef struct {
      int addr;
      int v0;
      int v1;
   } exp_t;

   exp_t qy[$];
   exp_t qc[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ny = 0, nc = 0, nd = 0;
   int last_wr  = -10;
   int first_acc = -1, first_en = -1;
   logic rnd_mode = 1'b0;
   logic stall_prev = 1'b0;
   int sv_y = 0, sv_c = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aq_ejpeg_rgb2ycbcr dut (
      .clk            (clk),
      .rst            (rst),
      .DataInit       (DataInit),
      .Start          (Start),
      .SubSamplingW   (SubSamplingW),
      .SubSamplingH   (SubSamplingH),
      .InValid        (InValid),
      .InReady        (InReady),
      .InR            (InR),
      .InG            (InG),
      .InB            (InB),
      .OutReady       (OutReady),
      .OutEnableY     (OutEnableY),
      .OutAddressY    (OutAddressY),
      .OutY           (OutY),
      .OutEnableCbCr  (OutEnableCbCr),
      .OutAddressCbCr (OutAddressCbCr),
      .OutCb          (OutCb),
      .OutCr          (OutCr),
      .Busy           (Busy),
      .Done           (Done)
   );

   task automatic chk(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // independent reference: real-valued Q14 sum, round half up, saturate
   function automatic int mdl(int kr, int kg, int kb, int r, int g, int b, int off);
      real v;
      int  t;
      v = real'(kr * r + kg * g + kb * b) + 8192.0;
      t = $rtoi($floor(v / 16384.0)) - off;
      if (t > 127) t = 127;
      if (t < -128) t = -128;
      return t;
   endfunction

   // downstream ready: constant high or random
   initial begin
      OutReady = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         OutReady = rnd_mode ? 1'($urandom_range(1)) : 1'b1;
      end
   end

   // write monitor / scoreboard consumer
   always @(negedge clk) begin
      exp_t e;
      if (rst && !DataInit) begin
         if (OutEnableY && first_en < 0) first_en = cyc;
         if (OutEnableY && OutReady) begin
            if (qy.size() == 0) chk("y_unexpected_write", 1, 0);
            else begin
               e = qy.pop_front();
               chk("y_addr", int'(OutAddressY), e.addr);
               chk("y_val", int'($signed(OutY)), e.v0);
            end
            ny++;
            last_wr = cyc;
         end
         if (OutEnableCbCr && OutReady) begin
            if (qc.size() == 0) chk("c_unexpected_write", 1, 0);
            else begin
               e = qc.pop_front();
               chk("c_addr", int'(OutAddressCbCr), e.addr);
               chk("cb_val", int'($signed(OutCb)), e.v0);
               chk("cr_val", int'($signed(OutCr)), e.v1);
            end
            nc++;
         end
         if (stall_prev) begin
            chk("hold_y", int'({OutEnableY, OutAddressY, OutY}), sv_y);
            chk("hold_c", int'({OutEnableCbCr, OutAddressCbCr, OutCb, OutCr}), sv_c);
         end
         stall_prev = (OutEnableY || OutEnableCbCr) && !OutReady;
         sv_y = int'({OutEnableY, OutAddressY, OutY});
         sv_c = int'({OutEnableCbCr, OutAddressCbCr, OutCb, OutCr});
         if (Done) begin
            nd++;
            chk("done_after_last_write", cyc, last_wr + 1);
            chk("done_queue_empty", qy.size() + qc.size(), 0);
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   // pat: 0 grey200, 1 primaries then random, 2 ramp, 3 random with gaps
   task automatic drive_mcu(input logic [1:0] ssw, input logic [1:0] ssh,
                            input int pat, input int stop_after);
      int   w, h, n, guard, r, g, b;
      logic acc;
      exp_t e;
      w = (ssw == 2'd2) ? 2 : 1;
      h = (ssh == 2'd2) ? 2 : 1;
      n = 0;
      SubSamplingW = ssw;
      SubSamplingH = ssh;
      Start = 1'b1;
      @(posedge clk);
      #1;
      Start = 1'b0;
      SubSamplingW = ~ssw;
      SubSamplingH = ~ssh;
      for (int yy = 0; yy < 8 * h && n < stop_after; yy++) begin
         for (int xx = 0; xx < 8 * w && n < stop_after; xx++) begin
            if (pat == 3 && $urandom_range(3) == 0) begin
               InValid = 1'b0;
               InR = 8'($urandom);
               @(posedge clk);
               #1;
            end
            case (pat)
               0: begin r = 200; g = 200; b = 200; end
               2: begin r = xx * 16 + yy; g = 255 - r; b = yy * 16; end
               default: begin
                  r = $urandom_range(255); g = $urandom_range(255); b = $urandom_range(255);
                  if (pat == 1 && n == 0) begin r = 255; g = 0; b = 0; end
                  if (pat == 1 && n == 1) begin r = 0; g = 0; b = 255; end
               end
            endcase
            InR = 8'(r); InG = 8'(g); InB = 8'(b);
            InValid = 1'b1;
            if (pat == 2 && n == 100) Start = 1'b1;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 1000) begin
               @(negedge clk);
               if (InReady) begin
                  acc = 1'b1;
                  if (n == 0) first_acc = cyc;
                  e.addr = yy * 16 + xx;
                  if (pat == 1 && n == 0)      e.v0 = -52;
                  else if (pat == 1 && n == 1) e.v0 = -99;
                  else                         e.v0 = mdl(4899, 9617, 1868, r, g, b, 128);
                  e.v1 = 0;
                  qy.push_back(e);
                  if ((w == 1 || xx % 2 == 0) && (h == 1 || yy % 2 == 0)) begin
                     e.addr = (((h == 2) ? yy / 2 : yy) << 3) | ((w == 2) ? xx / 2 : xx);
                     if (pat == 1 && n == 0) begin
                        e.v0 = -43; e.v1 = 127;
                     end else if (pat == 1 && n == 1) begin
                        e.v0 = 127; e.v1 = -21;
                     end else begin
                        e.v0 = mdl(-2765, -5427, 8192, r, g, b, 0);
                        e.v1 = mdl(8192, -6860, -1332, r, g, b, 0);
                     end
                     qc.push_back(e);
                  end
               end
               @(posedge clk);
               #1;
               Start = 1'b0;
               guard++;
            end
            if (!acc) begin
               chk("accept_timeout", 0, 1);
               n = stop_after;
            end else begin
               n++;
            end
         end
      end
      InValid = 1'b0;
   endtask

   task automatic wait_done(input int nd0);
      int guard;
      guard = 0;
      while (nd == nd0 && guard < 3000) begin
         @(posedge clk);
         guard++;
      end
      if (nd == nd0) chk("done_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ny0, nc0, nd0;
      rst = 1'b0; DataInit = 1'b0; Start = 1'b0; InValid = 1'b0;
      SubSamplingW = 2'd0; SubSamplingH = 2'd0;
      InR = 8'd0; InG = 8'd0; InB = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(Busy), 0);
      chk("rst_inready", int'(InReady), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_eny", int'(OutEnableY), 0);
      chk("rst_enc", int'(OutEnableCbCr), 0);
      chk("rst_y", int'(OutY), 0);
      chk("rst_addr_y", int'(OutAddressY), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 1x1 grey (non-2 factors treated as 1)
      ny0 = ny; nc0 = nc; nd0 = nd; first_en = -1;
      drive_mcu(2'd0, 2'd3, 0, 64);
      wait_done(nd0);
      chk("t1_ny", ny - ny0, 64);
      chk("t1_nc", nc - nc0, 64);
      chk("t1_nd", nd - nd0, 1);
      chk("t1_latency", first_en - first_acc, 4);
      chk("t1_busy_after", int'(Busy), 0);

      // 1x1 primaries then random
      ny0 = ny; nc0 = nc; nd0 = nd;
      drive_mcu(2'd1, 2'd1, 1, 64);
      wait_done(nd0);
      chk("t2_ny", ny - ny0, 64);
      chk("t2_nc", nc - nc0, 64);
      chk("t2_nd", nd - nd0, 1);

      // 2x2 ramp with ignored Start mid-run
      ny0 = ny; nc0 = nc; nd0 = nd;
      drive_mcu(2'd2, 2'd2, 2, 256);
      wait_done(nd0);
      chk("t3_ny", ny - ny0, 256);
      chk("t3_nc", nc - nc0, 64);
      chk("t3_nd", nd - nd0, 1);

      // 2x1 random data, random downstream stalls, input gaps
      rnd_mode = 1'b1;
      ny0 = ny; nc0 = nc; nd0 = nd;
      drive_mcu(2'd2, 2'd1, 3, 128);
      wait_done(nd0);
      rnd_mode = 1'b0;
      @(posedge clk);
      #1;
      chk("t4_ny", ny - ny0, 128);
      chk("t4_nc", nc - nc0, 64);
      chk("t4_nd", nd - nd0, 1);

      // abort at pixel 40 with Start colliding with DataInit
      drive_mcu(2'd1, 2'd1, 3, 40);
      DataInit = 1'b1;
      Start = 1'b1;
      @(posedge clk);
      #1;
      DataInit = 1'b0;
      Start = 1'b0;
      chk("t5_busy", int'(Busy), 0);
      chk("t5_eny", int'(OutEnableY), 0);
      chk("t5_enc", int'(OutEnableCbCr), 0);
      chk("t5_done", int'(Done), 0);
      ny0 = ny; nd0 = nd;
      repeat (6) @(posedge clk);
      #1;
      chk("t5_no_writes", ny - ny0, 0);
      chk("t5_no_done", nd - nd0, 0);
      chk("t5_still_idle", int'(Busy), 0);
      qy.delete();
      qc.delete();
      ny0 = ny; nc0 = nc; nd0 = nd;
      drive_mcu(2'd1, 2'd1, 3, 64);
      wait_done(nd0);
      chk("t5b_ny", ny - ny0, 64);
      chk("t5b_nc", nc - nc0, 64);
      chk("t5b_nd", nd - nd0, 1);

      // reset in the middle of an MCU
      drive_mcu(2'd1, 2'd1, 3, 20);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_busy", int'(Busy), 0);
      chk("t6_inready", int'(InReady), 0);
      chk("t6_eny", int'(OutEnableY), 0);
      chk("t6_enc", int'(OutEnableCbCr), 0);
      chk("t6_y", int'(OutY), 0);
      chk("t6_addr_y", int'(OutAddressY), 0);
      chk("t6_done", int'(Done), 0);
      rst = 1'b1;
      qy.delete();
      qc.delete();
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
